curve_lut_writer: RTL
=====================

Name: curve_lut_writer

Overview:
- Programmable writer/loader side of the camera-pipeline tone-curve LUT: accepts a valid/ready stream of curve entries, writes them sequentially into an internal DEPTH x WIDTH memory, and then serves clamped lookups.
- Replaces a fixed-init ROM, so the hw_output curve can be reloaded at runtime without regenerating the design.
- Sits between the host/config stream and the final hw_output stencil compute stage.

Parameters:
- WIDTH, 16, data width of each curve entry and of lookup output.
- DEPTH, 255, number of table entries (2..256).
- ADDR_W, 8, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse that begins a (re)load at entry 0.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  curve entry to write.
- load_ready  output  1  writer accepts load_data this cycle.
- load_done  output  1  one-cycle pulse when the final entry (DEPTH-1) is written.
- table_valid  output  1  table fully loaded and usable.
- lookup_en  input  1  lookup request this cycle.
- lookup_in  input  16  signed lookup index, before clamping.
- lookup_out  output  WIDTH  registered lookup result.
- lookup_vld  output  1  lookup_out is valid this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the write address to 0.
  - load_ready, load_done, table_valid, lookup_vld and lookup_out all go to 0.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: load_ready=0. load_start moves to LOAD.
  - LOAD: load_ready=1. A handshake (load_valid & load_ready) writes mem[waddr] <= load_data and increments waddr. The handshake at waddr==DEPTH-1 moves to DONE next cycle, with load_done=1 for exactly that cycle and table_valid=1 from then on.
  - DONE: load_ready=0. load_start moves to LOAD.
- Any load_start in any state:
  - Sets waddr=0 and table_valid=0 next cycle; state becomes LOAD.
  - If it coincides with a LOAD handshake, start wins and that data word is dropped (not written).
- Stalls: load_valid=0 in LOAD holds waddr; there is no timeout.
- Words offered outside LOAD: not accepted (load_ready=0), no effect.
- Lookup index clamp, applied combinationally:
  - lookup_in < 0 gives index 0.
  - lookup_in > DEPTH-1 gives index DEPTH-1.
  - Otherwise index = lookup_in[ADDR_W-1:0].
- Lookup latency is exactly 1 cycle:
  - lookup_vld(t+1) = lookup_en(t).
  - lookup_out(t+1) = mem[idx] if table_valid(t), else 0.
  - When lookup_en=0, lookup_out holds its previous value.
- Lookups during LOAD return 0, since table_valid=0. Lookups never stall the writer.
- Same-cycle write and lookup to the same address while table_valid=1 cannot occur, because writes only happen while table_valid=0.

Optional Feature:
- Macro CURVE_LUT_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output load_checksum [WIDTH], reset 0.
  - Cleared to 0 on load_start.
  - On each accepted write it becomes load_checksum + load_data, modulo 2^WIDTH.
  - Holds its value after DONE.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset while in LOAD at waddr=10 -> all outputs 0 immediately (async), state IDLE, table_valid stays 0 until a new full load.
- load_start, then stream entries k -> value 255-k with load_valid held high -> load_ready=1 for 255 cycles, load_done pulses once on the cycle after the 255th handshake, table_valid=1.
- After load: lookup_in=-5, 0, 100, 254, 1023 -> lookup_out one cycle later = 255, 255, 155, 1, 1 (values for indices 0, 0, 100, 254, 254).
- load_valid toggling 1/0 every cycle during load -> exactly 255 writes, done after 509 cycles in LOAD, contents correct.
- load_start asserted together with the handshake of entry 50 -> that word is dropped, waddr=0, table_valid=0, and a lookup of index 3 returns 0 until reload completes.
- With CURVE_LUT_WRITER_CHECKSUM_EN, load all entries = 16'h0101 -> load_checksum = 255*0x0101 mod 2^16 = 16'hFFFF.

Source files
------------

// File: rtl/curve_lut_writer.sv
// curve_lut_writer: runtime-loadable tone-curve LUT.
// A valid/ready stream fills DEPTH entries in order starting at entry 0;
// once the final entry lands, the table is marked valid and serves clamped,
// registered lookups with one cycle of latency.
// Optional build macro: CURVE_LUT_WRITER_CHECKSUM_EN adds load_checksum, a
// running modulo-2^WIDTH sum of the words accepted since the last load_start.
module curve_lut_writer #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 255,
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   input  logic                load_valid,
   input  logic [WIDTH-1:0]    load_data,
   output logic                load_ready,
   output logic                load_done,
   output logic                table_valid,
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
   output logic [WIDTH-1:0]    load_checksum,
`endif
   input  logic                lookup_en,
   input  logic signed [15:0]  lookup_in,
   output logic [WIDTH-1:0]    lookup_out,
   output logic                lookup_vld
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic signed [15:0] LAST_IDX  = 16'(DEPTH - 1);

   // Saturate a signed request index into the populated table range.
   function automatic logic [ADDR_W-1:0] clamp_index(input logic signed [15:0] x);
      if (x < 16'sd0) begin
         return '0;
      end else if (x > LAST_IDX) begin
         return LAST_ADDR;
      end else begin
         return x[ADDR_W-1:0];
      end
   endfunction

   logic [WIDTH-1:0]  mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              load_ready_q, load_ready_d;
   logic              load_done_q, load_done_d;
   logic              table_valid_q, table_valid_d;
   logic [WIDTH-1:0]  lookup_out_q, lookup_out_d;
   logic              lookup_vld_q, lookup_vld_d;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_idx;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
   logic [WIDTH-1:0]  checksum_q, checksum_d;
`endif

   assign rd_idx = clamp_index(lookup_in);

   // Next-state, write-enable and lookup result; load_start overrides any
   // handshake in the same cycle so that word is discarded.
   always_comb begin
      state_d       = state_q;
      waddr_d       = waddr_q;
      load_ready_d  = load_ready_q;
      load_done_d   = 1'b0;
      table_valid_d = table_valid_q;
      wr_en         = 1'b0;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
      checksum_d    = checksum_q;
`endif
      if (load_start) begin
         state_d       = S_LOAD;
         waddr_d       = '0;
         load_ready_d  = 1'b1;
         table_valid_d = 1'b0;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
         checksum_d    = '0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               if (load_valid && load_ready_q) begin
                  wr_en = 1'b1;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
                  checksum_d = checksum_q + load_data;
`endif
                  if (waddr_q == LAST_ADDR) begin
                     state_d       = S_DONE;
                     load_ready_d  = 1'b0;
                     load_done_d   = 1'b1;
                     table_valid_d = 1'b1;
                  end else begin
                     waddr_d = waddr_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               load_ready_d = 1'b0;
            end
         endcase
      end

      lookup_vld_d = lookup_en;
      lookup_out_d = lookup_out_q;
      if (lookup_en) begin
         lookup_out_d = table_valid_q ? mem[rd_idx] : '0;
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         waddr_q       <= '0;
         load_ready_q  <= 1'b0;
         load_done_q   <= 1'b0;
         table_valid_q <= 1'b0;
         lookup_out_q  <= '0;
         lookup_vld_q  <= 1'b0;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
         checksum_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         waddr_q       <= waddr_d;
         load_ready_q  <= load_ready_d;
         load_done_q   <= load_done_d;
         table_valid_q <= table_valid_d;
         lookup_out_q  <= lookup_out_d;
         lookup_vld_q  <= lookup_vld_d;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
         checksum_q    <= checksum_d;
`endif
      end
   end

   // Curve storage; deliberately not reset so a reset never wipes the curve.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr_q] <= load_data;
      end
   end

   assign load_ready  = load_ready_q;
   assign load_done   = load_done_q;
   assign table_valid = table_valid_q;
   assign lookup_out  = lookup_out_q;
   assign lookup_vld  = lookup_vld_q;
`ifdef CURVE_LUT_WRITER_CHECKSUM_EN
   assign load_checksum = checksum_q;
`endif

endmodule
